multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Multicycle control unit (UC) that sequences the RV64 datapath one instruction at a time: FETCH → DECODE → EXEC → MEM/WB.
- Drives every datapath load, enable and mux select.
- Arbitrates the data-memory handshake.
- Counts retired instructions.
- Halts on illegal encodings or memory timeout.

Parameters:
DM_WAIT_MAX, 0, max cycles in MEM waiting for dm_ready; 0 = unlimited.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
opcode  in  7  IR[6:0] from datapath
funct3  in  3  IR[14:12] from datapath
flags  in  6  ALU compare flags {bgeu,bltu,bge,blt,bne,beq}
dm_ready  in  1  data memory completes access this cycle
load_IR  out  1  IR load enable
load_PC  out  1  PC load enable
we_RF  out  1  register-file write enable
sel_ALU_A  out  1  1 = rs1, 0 = immediate
sel_ALU_B  out  1  1 = rs2, 0 = immediate
sel_PC_A  out  1  1 = PC, 0 = rs1[19:0]
sel_PC_B  out  1  1 = +4, 0 = immediate
sel_PC_RF  out  1  1 = PC+4, 0 = PC+imm
sel_imme  out  3  000 I, 001 S, 010 B, 011 J, 100 U
sel_RF_in  out  2  00 ALU, 01 DM, 11 PC_RF
dm_req  out  1  data memory access request
dm_we  out  1  data memory write (store)
halted  out  1  core stopped in TRAP
instret  out  CNT_W  retired-instruction count

Behaviour:
- State register and counters are reset asynchronously on rst=1. Reset state is FETCH; instret=0; wait counter=0.
- While rst=1, all outputs are 0.
- Outputs are combinational from the state register plus the latched-IR fields (opcode, funct3). Any output not listed for a state is 0.
- FETCH: load_IR=1 → DECODE. Every instruction starts with exactly one FETCH cycle.
- DECODE: sel_imme set per opcode → EXEC.
  - Supported opcodes: R 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, AUIPC 0010111.
  - Any other opcode, or BRANCH with funct3 010/011 → TRAP.
- EXEC, by class:
  - R: A=1, B=1 → WB.
  - OP-IMM: A=1, B=0, sel_imme=I → WB.
  - LOAD: A=1, B=0, sel_imme=I → MEM.
  - STORE: A=1, B=0, sel_imme=S → MEM.
  - BRANCH: A=1, B=1, sel_imme=B, load_PC=1, sel_PC_A=1, sel_PC_B=!taken → FETCH; retires.
  - JAL: we_RF=1, sel_RF_in=11, sel_PC_RF=1, sel_imme=J, load_PC=1, sel_PC_A=1, sel_PC_B=0 → FETCH; retires.
  - JALR: same as JAL except sel_imme=I and sel_PC_A=0. rd==rs1 is safe because the PC sum uses the pre-edge rs1.
  - AUIPC: we_RF=1, sel_RF_in=11, sel_PC_RF=0, sel_imme=U, load_PC=1, sel_PC_A=1, sel_PC_B=1 → FETCH; retires.
- Branch taken = the flag selected by funct3: 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu.
- MEM:
  - Hold the EXEC ALU selects so the address stays stable; dm_req=1; dm_we=1 for STORE.
  - While dm_ready=0: stay in MEM and increment the wait counter.
  - On dm_ready=1, LOAD: we_RF=1, sel_RF_in=01. Both classes: load_PC=1, sel_PC_A=1, sel_PC_B=1 → FETCH; retires.
  - dm_ready is ignored outside MEM.
  - If DM_WAIT_MAX≠0 and the wait counter reaches DM_WAIT_MAX without dm_ready → TRAP, with no RF write and no PC update.
  - Wait counter clears on MEM exit.
- WB: hold the EXEC ALU selects; we_RF=1, sel_RF_in=00, load_PC=1, sel_PC_A=1, sel_PC_B=1 → FETCH; retires.
- TRAP: halted=1, all strobes 0, no exit except rst.
- instret increments by 1 on every retiring cycle and wraps modulo 2^CNT_W.
- Reset mid-instruction (any state, including MEM with dm_req high) drops dm_req immediately; no partial write completes.
- CPI: R/OP-IMM 4; branch/JAL/JALR/AUIPC 3; load/store 4 plus wait cycles.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode localparams;
  - state encoding (FETCH, DECODE, EXEC, MEM, WB, TRAP);
  - sel_imme codes (IMM_I/S/B/J/U);
  - sel_RF_in codes (RFIN_ALU/DM/PC);
  - funct3 branch codes.
- One sub-module, branch_eval: combinational; funct3 + flags → taken, plus illegal_br.

Test Plan:
- ADD (opcode 0110011), dm_ready=0 → FETCH/DECODE/EXEC/WB; we_RF=1 and sel_RF_in=00 only in cycle 4; load_PC with sel_PC_B=1; instret 0→1.
- BEQ with flags[0]=1, then BEQ with flags[0]=0; BLTU with funct3=110 and flags[4]=1 → taken.
  - Taken: sel_PC_B=0 in EXEC, 3 cycles.
  - Not taken: sel_PC_B=1.
- LOAD with dm_ready low 3 cycles → MEM held 4 cycles, dm_req=1, dm_we=0; on ready, we_RF=1, sel_RF_in=01, load_PC=1. STORE with the same wait → dm_we=1, we_RF never 1.
- JAL: we_RF=1, sel_RF_in=11, sel_PC_RF=1, sel_imme=011, sel_PC_A=1, sel_PC_B=0, all in one cycle. JALR: identical except sel_PC_A=0, sel_imme=000.
- Opcode 0110111 (LUI), and BRANCH with funct3=010 → TRAP after DECODE, halted=1 held 20 cycles, instret frozen. rst=1 → FETCH, halted=0.
- DM_WAIT_MAX=5, dm_ready never asserted → TRAP after 5 MEM cycles. Separately, rst asserted mid-MEM → dm_req=0 in the same cycle and instret=0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV64 multicycle control unit: opcodes, FSM states,
// immediate/RF-input select codes, branch funct3 codes and instruction classes.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RFIN_ALU = 2'b00;
    localparam logic [1:0] RFIN_DM  = 2'b01;
    localparam logic [1:0] RFIN_PC  = 2'b11;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [3:0] {
        CL_R, CL_IMM, CL_LOAD, CL_STORE, CL_BRANCH,
        CL_JAL, CL_JALR, CL_AUIPC, CL_ILLEGAL
    } iclass_e;

    typedef struct packed {
        logic       load_ir;
        logic       load_pc;
        logic       we_rf;
        logic       alu_a;
        logic       alu_b;
        logic       pc_a;
        logic       pc_b;
        logic       pc_rf;
        logic [2:0] imme;
        logic [1:0] rf_in;
        logic       dm_req;
        logic       dm_we;
        logic       halted;
    } ctrl_t;

    function automatic iclass_e classify(input logic [6:0] op);
        case (op)
            OP_R:      return CL_R;
            OP_IMM:    return CL_IMM;
            OP_LOAD:   return CL_LOAD;
            OP_STORE:  return CL_STORE;
            OP_BRANCH: return CL_BRANCH;
            OP_JAL:    return CL_JAL;
            OP_JALR:   return CL_JALR;
            OP_AUIPC:  return CL_AUIPC;
            default:   return CL_ILLEGAL;
        endcase
    endfunction

    // R-type has no immediate; it falls to the I code so the mux stays quiet.
    function automatic logic [2:0] imm_for(input iclass_e c);
        case (c)
            CL_STORE:  return IMM_S;
            CL_BRANCH: return IMM_B;
            CL_JAL:    return IMM_J;
            CL_AUIPC:  return IMM_U;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/branch_eval.sv
// Branch condition selector: picks the ALU compare flag named by funct3 and
// flags the two funct3 values that have no branch meaning.
module branch_eval
    import riscv_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [5:0] flags,
    output logic       taken,
    output logic       illegal_br
);

    always_comb begin
        taken      = 1'b0;
        illegal_br = 1'b0;
        case (funct3)
            F3_BEQ:  taken = flags[0];
            F3_BNE:  taken = flags[1];
            F3_BLT:  taken = flags[2];
            F3_BGE:  taken = flags[3];
            F3_BLTU: taken = flags[4];
            F3_BGEU: taken = flags[5];
            default: illegal_br = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control unit for the RV64 datapath: FETCH/DECODE/EXEC/MEM/WB
// sequencing, data-memory handshake with optional timeout, retire counter.
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned DM_WAIT_MAX = 0,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [5:0]       flags,
    input  logic             dm_ready,
    output logic             load_IR,
    output logic             load_PC,
    output logic             we_RF,
    output logic             sel_ALU_A,
    output logic             sel_ALU_B,
    output logic             sel_PC_A,
    output logic             sel_PC_B,
    output logic             sel_PC_RF,
    output logic [2:0]       sel_imme,
    output logic [1:0]       sel_RF_in,
    output logic             dm_req,
    output logic             dm_we,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);

    localparam int WAIT_W = (DM_WAIT_MAX < 2) ? 1 : $clog2(DM_WAIT_MAX + 1);
    localparam logic [WAIT_W:0] WAIT_LIMIT = (WAIT_W + 1)'(DM_WAIT_MAX);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic [WAIT_W:0]   wait_inc;
    logic              retire;
    logic              taken;
    logic              illegal_br;
    iclass_e           cls;
    ctrl_t             ctl;
    ctrl_t             ctl_out;

    branch_eval u_branch_eval (
        .funct3     (funct3),
        .flags      (flags),
        .taken      (taken),
        .illegal_br (illegal_br)
    );

    assign cls      = classify(opcode);
    assign wait_inc = {1'b0, wait_q} + (WAIT_W + 1)'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        retire  = 1'b0;
        ctl     = '0;
        case (state_q)
            S_FETCH: begin
                ctl.load_ir = 1'b1;
                state_d     = S_DECODE;
            end
            S_DECODE: begin
                ctl.imme = imm_for(cls);
                if (cls == CL_ILLEGAL || (cls == CL_BRANCH && illegal_br)) begin
                    state_d = S_TRAP;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls)
                    CL_R: begin
                        ctl.alu_a = 1'b1;
                        ctl.alu_b = 1'b1;
                        state_d   = S_WB;
                    end
                    CL_IMM: begin
                        ctl.alu_a = 1'b1;
                        ctl.imme  = IMM_I;
                        state_d   = S_WB;
                    end
                    CL_LOAD, CL_STORE: begin
                        ctl.alu_a = 1'b1;
                        ctl.imme  = imm_for(cls);
                        state_d   = S_MEM;
                    end
                    CL_BRANCH: begin
                        ctl.alu_a   = 1'b1;
                        ctl.alu_b   = 1'b1;
                        ctl.imme    = IMM_B;
                        ctl.load_pc = 1'b1;
                        ctl.pc_a    = 1'b1;
                        ctl.pc_b    = !taken;
                        retire      = 1'b1;
                        state_d     = S_FETCH;
                    end
                    // JALR's PC sum reads rs1 before the edge, so rd == rs1 is safe.
                    CL_JAL, CL_JALR: begin
                        ctl.we_rf   = 1'b1;
                        ctl.rf_in   = RFIN_PC;
                        ctl.pc_rf   = 1'b1;
                        ctl.imme    = imm_for(cls);
                        ctl.load_pc = 1'b1;
                        ctl.pc_a    = (cls == CL_JAL);
                        ctl.pc_b    = 1'b0;
                        retire      = 1'b1;
                        state_d     = S_FETCH;
                    end
                    CL_AUIPC: begin
                        ctl.we_rf   = 1'b1;
                        ctl.rf_in   = RFIN_PC;
                        ctl.imme    = IMM_U;
                        ctl.load_pc = 1'b1;
                        ctl.pc_a    = 1'b1;
                        ctl.pc_b    = 1'b1;
                        retire      = 1'b1;
                        state_d     = S_FETCH;
                    end
                    default: state_d = S_TRAP;
                endcase
            end
            S_MEM: begin
                // Keep the EXEC address selects so the DM address is stable.
                ctl.alu_a  = 1'b1;
                ctl.imme   = imm_for(cls);
                ctl.dm_req = 1'b1;
                ctl.dm_we  = (cls == CL_STORE);
                if (dm_ready) begin
                    if (cls == CL_LOAD) begin
                        ctl.we_rf = 1'b1;
                        ctl.rf_in = RFIN_DM;
                    end
                    ctl.load_pc = 1'b1;
                    ctl.pc_a    = 1'b1;
                    ctl.pc_b    = 1'b1;
                    retire      = 1'b1;
                    wait_d      = '0;
                    state_d     = S_FETCH;
                end else if (DM_WAIT_MAX != 0 && wait_inc == WAIT_LIMIT) begin
                    wait_d  = '0;
                    state_d = S_TRAP;
                end else begin
                    wait_d = wait_inc[WAIT_W-1:0];
                end
            end
            S_WB: begin
                ctl.alu_a   = 1'b1;
                ctl.alu_b   = (cls == CL_R);
                ctl.imme    = imm_for(cls);
                ctl.we_rf   = 1'b1;
                ctl.rf_in   = RFIN_ALU;
                ctl.load_pc = 1'b1;
                ctl.pc_a    = 1'b1;
                ctl.pc_b    = 1'b1;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_TRAP: begin
                ctl.halted = 1'b1;
            end
            default: state_d = S_TRAP;
        endcase
    end

    assign instret_d = instret_q + CNT_W'(retire);

    // Reset forces every strobe low at once, even mid-access with dm_req high.
    assign ctl_out   = rst ? '0 : ctl;

    assign load_IR   = ctl_out.load_ir;
    assign load_PC   = ctl_out.load_pc;
    assign we_RF     = ctl_out.we_rf;
    assign sel_ALU_A = ctl_out.alu_a;
    assign sel_ALU_B = ctl_out.alu_b;
    assign sel_PC_A  = ctl_out.pc_a;
    assign sel_PC_B  = ctl_out.pc_b;
    assign sel_PC_RF = ctl_out.pc_rf;
    assign sel_imme  = ctl_out.imme;
    assign sel_RF_in = ctl_out.rf_in;
    assign dm_req    = ctl_out.dm_req;
    assign dm_we     = ctl_out.dm_we;
    assign halted    = ctl_out.halted;
    assign instret   = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: an unlimited-wait instance and a
// DM_WAIT_MAX=5 / 4-bit-counter instance, both checked against an instruction-level model.
module tb_multicycle_control;

    localparam logic [6:0] T_R     = 7'b0110011;
    localparam logic [6:0] T_IMM   = 7'b0010011;
    localparam logic [6:0] T_LOAD  = 7'b0000011;
    localparam logic [6:0] T_STORE = 7'b0100011;
    localparam logic [6:0] T_BR    = 7'b1100011;
    localparam logic [6:0] T_JAL   = 7'b1101111;
    localparam logic [6:0] T_JALR  = 7'b1100111;
    localparam logic [6:0] T_AUIPC = 7'b0010111;
    localparam logic [6:0] T_LUI   = 7'b0110111;

    typedef struct packed {
        logic       halted;
        logic       dm_we;
        logic       dm_req;
        logic [1:0] rfin;
        logic [2:0] imm;
        logic       pcrf;
        logic       pcb;
        logic       pca;
        logic       alub;
        logic       alua;
        logic       we;
        logic       ldpc;
        logic       ldir;
    } ov_t;

    localparam ov_t HALT_V = 16'h8000;

    logic       clk, rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [5:0] flags;
    logic       dm_ready;

    logic load_IR_a, load_PC_a, we_RF_a, sel_ALU_A_a, sel_ALU_B_a, sel_PC_A_a, sel_PC_B_a, sel_PC_RF_a;
    logic [2:0] sel_imme_a;
    logic [1:0] sel_RF_in_a;
    logic dm_req_a, dm_we_a, halted_a;
    logic [31:0] instret_a;

    logic load_IR_b, load_PC_b, we_RF_b, sel_ALU_A_b, sel_ALU_B_b, sel_PC_A_b, sel_PC_B_b, sel_PC_RF_b;
    logic [2:0] sel_imme_b;
    logic [1:0] sel_RF_in_b;
    logic dm_req_b, dm_we_b, halted_b;
    logic [3:0] instret_b;

    ov_t got_a, got_b;
    assign got_a = {halted_a, dm_we_a, dm_req_a, sel_RF_in_a, sel_imme_a, sel_PC_RF_a,
                    sel_PC_B_a, sel_PC_A_a, sel_ALU_B_a, sel_ALU_A_a, we_RF_a, load_PC_a, load_IR_a};
    assign got_b = {halted_b, dm_we_b, dm_req_b, sel_RF_in_b, sel_imme_b, sel_PC_RF_b,
                    sel_PC_B_b, sel_PC_A_b, sel_ALU_B_b, sel_ALU_A_b, we_RF_b, load_PC_b, load_IR_b};

    multicycle_control #(.DM_WAIT_MAX(0), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .flags(flags), .dm_ready(dm_ready),
        .load_IR(load_IR_a), .load_PC(load_PC_a), .we_RF(we_RF_a), .sel_ALU_A(sel_ALU_A_a),
        .sel_ALU_B(sel_ALU_B_a), .sel_PC_A(sel_PC_A_a), .sel_PC_B(sel_PC_B_a), .sel_PC_RF(sel_PC_RF_a),
        .sel_imme(sel_imme_a), .sel_RF_in(sel_RF_in_a), .dm_req(dm_req_a), .dm_we(dm_we_a),
        .halted(halted_a), .instret(instret_a)
    );

    multicycle_control #(.DM_WAIT_MAX(5), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .flags(flags), .dm_ready(dm_ready),
        .load_IR(load_IR_b), .load_PC(load_PC_b), .we_RF(we_RF_b), .sel_ALU_A(sel_ALU_A_b),
        .sel_ALU_B(sel_ALU_B_b), .sel_PC_A(sel_PC_A_b), .sel_PC_B(sel_PC_B_b), .sel_PC_RF(sel_PC_RF_b),
        .sel_imme(sel_imme_b), .sel_RF_in(sel_RF_in_b), .dm_req(dm_req_b), .dm_we(dm_we_b),
        .halted(halted_b), .instret(instret_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk, n_pass;
    logic [31:0] ret_a;
    logic [3:0]  ret_b;
    bit          halt_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    endtask

    function automatic bit op_known(input logic [6:0] op);
        return op == T_R || op == T_IMM || op == T_LOAD || op == T_STORE ||
               op == T_BR || op == T_JAL || op == T_JALR || op == T_AUIPC;
    endfunction

    function automatic bit instr_legal(input logic [6:0] op, input logic [2:0] f3);
        return op_known(op) && !(op == T_BR && (f3 == 3'b010 || f3 == 3'b011));
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (op)
            T_STORE: return 3'b001;
            T_BR:    return 3'b010;
            T_JAL:   return 3'b011;
            T_AUIPC: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // One clock of observation: compare both instances, then advance the model.
    task automatic cyc(input string tag, input ov_t e, input bit retire, input bit trap_b);
        ov_t eb;
        #1;
        eb = halt_b ? HALT_V : e;
        check({tag, "_a"}, 32'(got_a), 32'(e));
        check({tag, "_ia"}, instret_a, ret_a);
        check({tag, "_b"}, 32'(got_b), 32'(eb));
        check({tag, "_ib"}, 32'(instret_b), 32'(ret_b));
        if (retire) begin
            ret_a = ret_a + 32'd1;
            if (!halt_b) ret_b = ret_b + 4'd1;
        end
        if (trap_b) halt_b = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_ctl_a", 32'(got_a), 32'd0);
        check("rst_ins_a", instret_a, 32'd0);
        check("rst_ctl_b", 32'(got_b), 32'd0);
        check("rst_ins_b", 32'(instret_b), 32'd0);
        ret_a  = '0;
        ret_b  = '0;
        halt_b = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic trap_hold(input int n);
        for (int i = 0; i < n; i++) begin
            opcode   = 7'($urandom);
            dm_ready = 1'($urandom);
            cyc("trap", HALT_V, 1'b0, 1'b0);
        end
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [5:0] fl,
                             input int nwait, input int rst_at_mem);
        ov_t e;
        bit  rdy;
        bit  one_shot;
        int  flag_of[8];
        flag_of = '{0, 1, -1, -1, 2, 3, 4, 5};
        opcode   = 7'($urandom);
        funct3   = 3'($urandom);
        flags    = 6'($urandom);
        dm_ready = 1'($urandom);
        e = '0;
        e.ldir = 1'b1;
        cyc("fetch", e, 1'b0, 1'b0);
        opcode   = op;
        funct3   = f3;
        flags    = fl;
        dm_ready = 1'($urandom);
        e = '0;
        e.imm = imm_of(op);
        cyc("decode", e, 1'b0, 1'b0);
        if (!instr_legal(op, f3)) begin
            halt_b = 1'b1;
            return;
        end
        dm_ready = 1'($urandom);
        e = '0;
        e.imm = imm_of(op);
        case (op)
            T_R:                    begin e.alua = 1'b1; e.alub = 1'b1; end
            T_IMM, T_LOAD, T_STORE: e.alua = 1'b1;
            T_BR: begin
                e.alua = 1'b1; e.alub = 1'b1; e.ldpc = 1'b1; e.pca = 1'b1;
                e.pcb  = !fl[flag_of[f3]];
            end
            T_JAL, T_JALR: begin
                e.we = 1'b1; e.rfin = 2'b11; e.pcrf = 1'b1; e.ldpc = 1'b1;
                e.pca = (op == T_JAL); e.pcb = 1'b0;
            end
            default: begin
                e.we = 1'b1; e.rfin = 2'b11; e.ldpc = 1'b1; e.pca = 1'b1; e.pcb = 1'b1;
            end
        endcase
        one_shot = (op == T_BR || op == T_JAL || op == T_JALR || op == T_AUIPC);
        cyc("exec", e, one_shot, 1'b0);
        if (one_shot) return;
        if (op == T_R || op == T_IMM) begin
            dm_ready = 1'($urandom);
            e.we = 1'b1; e.rfin = 2'b00; e.ldpc = 1'b1; e.pca = 1'b1; e.pcb = 1'b1;
            cyc("wb", e, 1'b1, 1'b0);
            return;
        end
        e.dm_req = 1'b1;
        e.dm_we  = (op == T_STORE);
        for (int k = 1; k <= nwait + 1; k++) begin
            rdy      = (k == nwait + 1);
            dm_ready = rdy;
            if (k == rst_at_mem) begin
                #1;
                check("mem_req_pre_rst", 32'(dm_req_a), 32'd1);
                do_reset();
                return;
            end
            if (rdy) begin
                e.ldpc = 1'b1; e.pca = 1'b1; e.pcb = 1'b1;
                if (op == T_LOAD) begin e.we = 1'b1; e.rfin = 2'b01; end
            end
            // The limited instance gives up on its fifth unanswered MEM cycle.
            cyc("mem", e, rdy, !rdy && k == 5);
        end
    endtask

    int          r, nw, rm;
    logic [6:0]  rop;
    logic [2:0]  rf3;
    logic [5:0]  rfl;

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end

    initial begin
        n_chk = 0; n_pass = 0;
        ret_a = '0; ret_b = '0; halt_b = 1'b0;
        rst = 1'b1; opcode = '0; funct3 = '0; flags = '0; dm_ready = 1'b0;
        #2;
        check("init_ctl_a", 32'(got_a), 32'd0);
        check("init_ins_a", instret_a, 32'd0);
        check("init_ctl_b", 32'(got_b), 32'd0);
        check("init_ins_b", 32'(instret_b), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Twenty ADDs carry the 4-bit counter of the second instance past its wrap.
        for (int i = 0; i < 20; i++) run_instr(T_R, 3'b000, 6'($urandom), 0, 0);
        run_instr(T_BR, 3'b000, 6'b000001, 0, 0);
        run_instr(T_BR, 3'b000, 6'b111110, 0, 0);
        run_instr(T_BR, 3'b110, 6'b010000, 0, 0);
        run_instr(T_LOAD, 3'b011, 6'($urandom), 3, 0);
        run_instr(T_STORE, 3'b011, 6'($urandom), 3, 0);
        run_instr(T_JAL, 3'($urandom), 6'($urandom), 0, 0);
        run_instr(T_JALR, 3'b000, 6'($urandom), 0, 0);
        run_instr(T_AUIPC, 3'($urandom), 6'($urandom), 0, 0);
        run_instr(T_IMM, 3'($urandom), 6'($urandom), 0, 0);

        run_instr(T_LUI, 3'b000, 6'($urandom), 0, 0);
        trap_hold(20);
        do_reset();
        run_instr(T_BR, 3'b010, 6'($urandom), 0, 0);
        trap_hold(20);
        do_reset();

        run_instr(T_R, 3'b000, 6'($urandom), 0, 0);
        run_instr(T_LOAD, 3'b000, 6'($urandom), 8, 0);
        run_instr(T_R, 3'b000, 6'($urandom), 0, 0);
        do_reset();
        run_instr(T_R, 3'b000, 6'($urandom), 0, 0);
        run_instr(T_STORE, 3'b010, 6'($urandom), 10, 3);

        for (int i = 0; i < 150; i++) begin
            r   = $urandom_range(0, 11);
            rf3 = 3'($urandom);
            rfl = 6'($urandom);
            nw  = $urandom_range(0, 6);
            rm  = 0;
            case (r)
                0:       rop = T_R;
                1:       rop = T_IMM;
                2, 3:    rop = T_LOAD;
                4:       rop = T_STORE;
                5, 6:    rop = T_BR;
                7:       rop = T_JAL;
                8:       rop = T_JALR;
                9:       rop = T_AUIPC;
                10: begin
                    do rop = 7'($urandom); while (op_known(rop));
                end
                default: begin
                    rop = ($urandom_range(0, 1) == 1) ? T_LOAD : T_STORE;
                    rm  = $urandom_range(1, nw + 1);
                end
            endcase
            run_instr(rop, rf3, rfl, nw, rm);
            if (!instr_legal(rop, rf3)) begin
                trap_hold($urandom_range(1, 4));
                do_reset();
            end else if (halt_b) begin
                do_reset();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
